// File: rtl/scanport_pkg.sv
// scanport_pkg: pin drive-mode codes, IEEE 1149.1 TAP state encoding, cfg_data
// field positions and the pad/TAP helper functions shared by the scanport bank.
package scanport_pkg;

    typedef enum logic [2:0] {
        MODE_HIZ   = 3'b000,
        MODE_OD    = 3'b001,
        MODE_OS    = 3'b010,
        MODE_HIZ_3 = 3'b011,
        MODE_LOW   = 3'b100,
        MODE_HIGH  = 3'b101,
        MODE_PP    = 3'b110,
        MODE_HIZ_7 = 3'b111
    } pin_mode_e;

    // Bit layout matches cfg_data[5:0]: mode_a = TCK/TDO, mode_b = TMS/TRST.
    typedef struct packed {
        pin_mode_e mode_b;
        pin_mode_e mode_a;
    } pin_pair_t;

    typedef struct packed {
        logic val;
        logic oe;
    } pad_t;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RTI        = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_TLR        = 4'hF
    } tap_state_e;

    localparam int CFG_PAIR_W    = 6;
    localparam int CFG_SPARE_BIT = 6;
    localparam int CFG_IMM_BIT   = 7;

    function automatic pad_t pin_drive(input pin_mode_e mode, input logic in_val);
        pad_t pad;
        pad = '{val: 1'b0, oe: 1'b0};
        case (mode)
            MODE_OD:   pad.oe = ~in_val;
            MODE_OS:   pad = '{val: 1'b1, oe: in_val};
            MODE_LOW:  pad.oe = 1'b1;
            MODE_HIGH: pad = '{val: 1'b1, oe: 1'b1};
            MODE_PP:   pad = '{val: in_val, oe: 1'b1};
            default:   pad = '{val: 1'b0, oe: 1'b0};
        endcase
        return pad;
    endfunction

    // Level seen on the pad net; an undriven pin is pulled high.
    function automatic logic pad_level(input pad_t pad);
        return pad.oe ? pad.val : 1'b1;
    endfunction

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TAP_TLR:        return tms ? TAP_TLR        : TAP_RTI;
            TAP_RTI:        return tms ? TAP_SELECT_DR  : TAP_RTI;
            TAP_SELECT_DR:  return tms ? TAP_SELECT_IR  : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: return tms ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   return tms ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   return tms ? TAP_UPDATE_DR  : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   return tms ? TAP_EXIT2_DR   : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   return tms ? TAP_UPDATE_DR  : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  return tms ? TAP_SELECT_DR  : TAP_RTI;
            TAP_SELECT_IR:  return tms ? TAP_TLR        : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: return tms ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   return tms ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   return tms ? TAP_UPDATE_IR  : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   return tms ? TAP_EXIT2_IR   : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   return tms ? TAP_UPDATE_IR  : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  return tms ? TAP_SELECT_DR  : TAP_RTI;
            default:        return TAP_TLR;
        endcase
    endfunction

endpackage

// File: rtl/scanport_driver_bank_tap_monitor.sv
// tap_monitor: clk-domain observer of one scanport (synchronisers, TCK edge detect,
// TAP FSM, idle timer). Edge counter built only with SCANPORT_TCK_COUNT_EN defined.
module tap_monitor
    import scanport_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tck_in,
    input  logic        tms_in,
    input  logic        trst_n_in,
    input  logic        cnt_clr,
    output tap_state_e  tap_state,
    output logic        port_idle,
    output logic [15:0] tck_count
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

    // Each stage holds {tck, tms, trst_n}; all three travel together so TMS
    // is aligned with the TCK edge it qualifies.
    logic [2:0]        sync_q [SYNC_STAGES];
    logic [2:0]        sync_d [SYNC_STAGES];
    logic              tck_prev_q, tck_prev_d;
    tap_state_e        state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              tck_s, tms_s, trst_n_s, tck_rise;

    assign {tck_s, tms_s, trst_n_s} = sync_q[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev_q;

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        sync_d[0] = {tck_in, tms_in, trst_n_in};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        tck_prev_d = tck_s;

        state_d = state_q;
        if (!trst_n_s) begin
            state_d = TAP_TLR;
        end else if (tck_rise) begin
            state_d = tap_next(state_q, tms_s);
        end

        idle_cnt_d = idle_cnt_q;
        if (tck_rise) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // Synchronisers reset to the undriven-pad level so release never fakes a TCK edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            tck_prev_q <= 1'b1;
            state_q    <= TAP_TLR;
            idle_cnt_q <= IDLE_MAX;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            tck_prev_q <= tck_prev_d;
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign tap_state = state_q;
    assign port_idle = (idle_cnt_q == IDLE_MAX);

`ifdef SCANPORT_TCK_COUNT_EN
    logic [15:0] edge_cnt_q, edge_cnt_d;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (cnt_clr) begin
            edge_cnt_d = '0;
        end else if (tck_rise) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign tck_count = edge_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign tck_count      = '0;
`endif

endmodule

// File: rtl/scanport_driver_bank.sv
// scanport_driver_bank: NUM_PORTS JTAG pad drivers with deferred (glitch-safe) mode
// changes and per-port TAP monitors. Optional TCK edge counters: SCANPORT_TCK_COUNT_EN.
module scanport_driver_bank
    import scanport_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 1024,
    localparam int PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_wr,
    input  logic [PORT_W-1:0]      cfg_port,
    input  logic                   cfg_sel,
    input  logic [7:0]             cfg_data,
    output logic                   cfg_ack,
    input  logic [NUM_PORTS-1:0]   tck_fpga,
    input  logic [NUM_PORTS-1:0]   tms_fpga,
    input  logic [NUM_PORTS-1:0]   tdo_fpga,
    input  logic [NUM_PORTS-1:0]   trst_fpga,
    output logic [NUM_PORTS-1:0]   sp_tck,
    output logic [NUM_PORTS-1:0]   sp_tms,
    output logic [NUM_PORTS-1:0]   sp_tdo,
    output logic [NUM_PORTS-1:0]   sp_trst_n,
    output logic [NUM_PORTS-1:0]   sp_tck_oe,
    output logic [NUM_PORTS-1:0]   sp_tms_oe,
    output logic [NUM_PORTS-1:0]   sp_tdo_oe,
    output logic [NUM_PORTS-1:0]   sp_trst_n_oe,
    output logic [4*NUM_PORTS-1:0] tap_state,
    output logic [NUM_PORTS-1:0]   port_idle,
    output logic [16*NUM_PORTS-1:0] tck_count
);

    // Register index 0 = TCK/TMS, 1 = TDO/TRST.
    pin_pair_t  shadow_q  [NUM_PORTS][2];
    pin_pair_t  shadow_d  [NUM_PORTS][2];
    pin_pair_t  active_q  [NUM_PORTS][2];
    pin_pair_t  active_d  [NUM_PORTS][2];
    logic       pending_q [NUM_PORTS][2];
    logic       pending_d [NUM_PORTS][2];
    logic       imm_q     [NUM_PORTS][2];
    logic       imm_d     [NUM_PORTS][2];
    logic       cfg_ack_q, cfg_ack_d;
    logic       port_ok;
    logic [NUM_PORTS-1:0] port_wr;
    logic [NUM_PORTS-1:0] xfer_ok;
    tap_state_e mon_state [NUM_PORTS];

    logic unused_cfg_spare;
    assign unused_cfg_spare = cfg_data[CFG_SPARE_BIT];

    // Transfer first, then a same-cycle write refills the shadow and re-arms pending.
    always_comb begin
        cfg_ack_d = cfg_wr;
        port_ok   = cfg_wr && (32'(cfg_port) < 32'(NUM_PORTS));
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_wr[p] = port_ok && (32'(cfg_port) == 32'(p));
            for (int r = 0; r < 2; r++) begin
                shadow_d[p][r]  = shadow_q[p][r];
                active_d[p][r]  = active_q[p][r];
                pending_d[p][r] = pending_q[p][r];
                imm_d[p][r]     = imm_q[p][r];
                if (pending_q[p][r] && (imm_q[p][r] || xfer_ok[p])) begin
                    active_d[p][r]  = shadow_q[p][r];
                    pending_d[p][r] = 1'b0;
                end
                if (port_wr[p] && (cfg_sel == 1'(r))) begin
                    shadow_d[p][r]  = pin_pair_t'(cfg_data[CFG_PAIR_W-1:0]);
                    pending_d[p][r] = 1'b1;
                    imm_d[p][r]     = cfg_data[CFG_IMM_BIT];
                end
            end
        end
    end

    // NOTE: the register file is reset explicitly so the pads come up hi-z.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_ack_q <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int r = 0; r < 2; r++) begin
                    shadow_q[p][r]  <= '0;
                    active_q[p][r]  <= '0;
                    pending_q[p][r] <= 1'b0;
                    imm_q[p][r]     <= 1'b0;
                end
            end
        end else begin
            cfg_ack_q <= cfg_ack_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int r = 0; r < 2; r++) begin
                    shadow_q[p][r]  <= shadow_d[p][r];
                    active_q[p][r]  <= active_d[p][r];
                    pending_q[p][r] <= pending_d[p][r];
                    imm_q[p][r]     <= imm_d[p][r];
                end
            end
        end
    end

    assign cfg_ack = cfg_ack_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        pad_t tck_pad, tms_pad, tdo_pad, trst_pad;

        assign tck_pad  = pin_drive(active_q[p][0].mode_a, tck_fpga[p]);
        assign tms_pad  = pin_drive(active_q[p][0].mode_b, tms_fpga[p]);
        assign tdo_pad  = pin_drive(active_q[p][1].mode_a, tdo_fpga[p]);
        assign trst_pad = pin_drive(active_q[p][1].mode_b, trst_fpga[p]);

        assign sp_tck[p]       = tck_pad.val;
        assign sp_tck_oe[p]    = tck_pad.oe;
        assign sp_tms[p]       = tms_pad.val;
        assign sp_tms_oe[p]    = tms_pad.oe;
        assign sp_tdo[p]       = tdo_pad.val;
        assign sp_tdo_oe[p]    = tdo_pad.oe;
        assign sp_trst_n[p]    = trst_pad.val;
        assign sp_trst_n_oe[p] = trst_pad.oe;

        // Mode changes are safe only where a glitch cannot move the target TAP.
        assign xfer_ok[p] = port_idle[p] || (mon_state[p] == TAP_TLR)
                                         || (mon_state[p] == TAP_RTI);

        tap_monitor #(
            .SYNC_STAGES  (SYNC_STAGES),
            .IDLE_TIMEOUT (IDLE_TIMEOUT)
        ) u_tap_monitor (
            .clk       (clk),
            .reset     (reset),
            .tck_in    (pad_level(tck_pad)),
            .tms_in    (pad_level(tms_pad)),
            .trst_n_in (pad_level(trst_pad)),
            .cnt_clr   (port_wr[p]),
            .tap_state (mon_state[p]),
            .port_idle (port_idle[p]),
            .tck_count (tck_count[16*p +: 16])
        );

        assign tap_state[4*p +: 4] = mon_state[p];
    end

endmodule

// File: tb/tb_scanport_driver_bank.sv
// tb_scanport_driver_bank: self-checking bench; TAP expectations flow through a
// scoreboard queue fed by a reference TAP model as TCK pulses are driven.
module tb_scanport_driver_bank;

    localparam int NP   = 2;
    localparam int PW   = 1;
    localparam int SYNC = 2;
    localparam int IDLE = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_wr;
    logic [PW-1:0]   cfg_port;
    logic            cfg_sel;
    logic [7:0]      cfg_data;
    logic            cfg_ack;
    logic [NP-1:0]   tck_fpga, tms_fpga, tdo_fpga, trst_fpga;
    logic [NP-1:0]   sp_tck, sp_tms, sp_tdo, sp_trst_n;
    logic [NP-1:0]   sp_tck_oe, sp_tms_oe, sp_tdo_oe, sp_trst_n_oe;
    logic [4*NP-1:0] tap_state;
    logic [NP-1:0]   port_idle;
    logic [16*NP-1:0] tck_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_tap;
    logic       trst_forced;
    logic [3:0] sb_q [$];

    scanport_driver_bank #(
        .NUM_PORTS    (NP),
        .SYNC_STAGES  (SYNC),
        .IDLE_TIMEOUT (IDLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr       (cfg_wr),
        .cfg_port     (cfg_port),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .cfg_ack      (cfg_ack),
        .tck_fpga     (tck_fpga),
        .tms_fpga     (tms_fpga),
        .tdo_fpga     (tdo_fpga),
        .trst_fpga    (trst_fpga),
        .sp_tck       (sp_tck),
        .sp_tms       (sp_tms),
        .sp_tdo       (sp_tdo),
        .sp_trst_n    (sp_trst_n),
        .sp_tck_oe    (sp_tck_oe),
        .sp_tms_oe    (sp_tms_oe),
        .sp_tdo_oe    (sp_tdo_oe),
        .sp_trst_n_oe (sp_trst_n_oe),
        .tap_state    (tap_state),
        .port_idle    (port_idle),
        .tck_count    (tck_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference TAP transition table, written as {next_on_tms0, next_on_tms1}.
    function automatic logic [3:0] tap_model(input logic [3:0] s, input logic tms);
        logic [7:0] nx;
        case (s)
            4'h0: nx = 8'h25;  4'h1: nx = 8'h35;  4'h2: nx = 8'h21;  4'h3: nx = 8'h30;
            4'h4: nx = 8'hEF;  4'h5: nx = 8'hC7;  4'h6: nx = 8'h21;  4'h7: nx = 8'h64;
            4'h8: nx = 8'hAD;  4'h9: nx = 8'hBD;  4'hA: nx = 8'hA9;  4'hB: nx = 8'hB8;
            4'hC: nx = 8'hC7;  4'hD: nx = 8'hC7;  4'hE: nx = 8'hA9;  default: nx = 8'hCF;
        endcase
        return tms ? nx[3:0] : nx[7:4];
    endfunction

    // Expected {value, oe} of a pad for a drive mode and controller input.
    function automatic logic [1:0] exp_pad(input logic [2:0] m, input logic in_v);
        case (m)
            3'b001:  return {1'b0, ~in_v};
            3'b010:  return {1'b1, in_v};
            3'b100:  return 2'b01;
            3'b101:  return 2'b11;
            3'b110:  return {in_v, 1'b1};
            default: return 2'b00;
        endcase
    endfunction

    task automatic cfg_write(input int port, input logic sel, input logic [7:0] data);
        cfg_wr   = 1'b1;
        cfg_port = PW'(port);
        cfg_sel  = sel;
        cfg_data = data;
        step(1);
        cfg_wr   = 1'b0;
    endtask

    task automatic sb_check(input string tag);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(0), 32'(1));
        end else begin
            check(tag, 32'(tap_state[3:0]), 32'(sb_q.pop_front()));
        end
    endtask

    // One port-0 TCK period (4 clk low, 4 clk high); tap_state checked after the monitor latency.
    task automatic tck_pulse(input logic tms);
        tms_fpga[0] = tms;
        tck_fpga[0] = 1'b0;
        step(4);
        tck_fpga[0] = 1'b1;
        exp_tap = trst_forced ? 4'hF : tap_model(exp_tap, tms);
        sb_q.push_back(exp_tap);
        step(SYNC + 2);
        sb_check("tap_pulse");
    endtask

    initial begin
        logic [2:0] m;
        logic       in_v;
        reset = 1'b1;
        cfg_wr = 1'b0; cfg_port = '0; cfg_sel = 1'b0; cfg_data = '0;
        tck_fpga = '0; tms_fpga = '0; tdo_fpga = '0; trst_fpga = '0;
        trst_forced = 1'b0;
        exp_tap = 4'hF;

        // Reset with everything toggling.
        for (int i = 0; i < 6; i++) begin
            tck_fpga  = 2'($urandom); tms_fpga = 2'($urandom);
            tdo_fpga  = 2'($urandom); trst_fpga = 2'($urandom);
            cfg_wr    = 1'($urandom); cfg_data = 8'($urandom);
            step(1);
        end
        check("rst_oe", 32'({sp_tck_oe, sp_tms_oe, sp_tdo_oe, sp_trst_n_oe}), 32'(0));
        check("rst_val", 32'({sp_tck, sp_tms, sp_tdo, sp_trst_n}), 32'(0));
        check("rst_tap", 32'(tap_state), 32'(8'hFF));
        check("rst_idle", 32'(port_idle), 32'(2'b11));
        check("rst_ack", 32'(cfg_ack), 32'(0));
        check("rst_count", tck_count, 32'(0));
        cfg_wr = 1'b0;
        tck_fpga = '0; tms_fpga = '0; tdo_fpga = '0; trst_fpga = '0;
        step(1);
        reset = 1'b0;
        step(2);

        // Port 0 TCK/TMS push-pull while idle.
        cfg_write(0, 1'b0, 8'h36);
        check("ack_pulse", 32'(cfg_ack), 32'(1));
        check("tck_oe_before_xfer", 32'(sp_tck_oe[0]), 32'(0));
        step(1);
        check("ack_done", 32'(cfg_ack), 32'(0));
        check("tck_oe_after_xfer", 32'(sp_tck_oe[0]), 32'(1));
        check("tms_oe_after_xfer", 32'(sp_tms_oe[0]), 32'(1));
        check("port1_untouched", 32'(sp_tck_oe[1]), 32'(0));
        tck_fpga[0] = 1'b1;
        #1 check("tck_pass_hi", 32'(sp_tck[0]), 32'(1));
        tck_fpga[0] = 1'b0;
        #1 check("tck_pass_lo", 32'(sp_tck[0]), 32'(0));
        step(SYNC + 2);

        // First TCK edge with exact monitor latency: TLR -> RTI.
        tms_fpga[0] = 1'b0;
        step(4);
        tck_fpga[0] = 1'b1;
        exp_tap = tap_model(exp_tap, 1'b0);
        step(SYNC);
        check("tap_latency_early", 32'(tap_state[3:0]), 32'(4'hF));
        step(1);
        check("tap_latency", 32'(tap_state[3:0]), 32'(exp_tap));
        check("idle_cleared", 32'(port_idle[0]), 32'(0));
        step(1);
        tck_pulse(1'b1);
        tck_pulse(1'b0);
        tck_pulse(1'b0);
        tck_pulse(1'b0);

        // Deferred TDO tie-low while in SHIFT_DR.
        tdo_fpga[0] = 1'b1;
        cfg_write(0, 1'b1, 8'h04);
        step(1);
        check("tdo_deferred", 32'(sp_tdo_oe[0]), 32'(0));
        tck_pulse(1'b0);
        tck_pulse(1'b1);
        tck_pulse(1'b1);
        check("tdo_deferred_upd", 32'(sp_tdo_oe[0]), 32'(0));
        tms_fpga[0] = 1'b0;
        tck_fpga[0] = 1'b0;
        step(4);
        tck_fpga[0] = 1'b1;
        exp_tap = tap_model(exp_tap, 1'b0);
        step(SYNC + 1);
        check("tap_rti", 32'(tap_state[3:0]), 32'(exp_tap));
        check("tdo_oe_at_rti", 32'(sp_tdo_oe[0]), 32'(0));
        step(1);
        check("tdo_oe_applied", 32'(sp_tdo_oe[0]), 32'(1));
        check("tdo_low_applied", 32'(sp_tdo[0]), 32'(0));

        // Immediate write in SHIFT_DR.
        tck_pulse(1'b1);
        tck_pulse(1'b0);
        tck_pulse(1'b0);
        cfg_write(0, 1'b1, 8'h85);
        check("imm_before", 32'(sp_tdo[0]), 32'(0));
        step(1);
        check("imm_applied", 32'({sp_tdo[0], sp_tdo_oe[0]}), 32'(2'b11));
        check("imm_in_shift_dr", 32'(tap_state[3:0]), 32'(4'h2));

        // Write landing in the transfer cycle: old shadow goes active, new stays pending.
        cfg_write(0, 1'b1, 8'h86);
        cfg_write(0, 1'b1, 8'h01);
        check("overlap_active_pp", 32'({sp_tdo[0], sp_tdo_oe[0]}), 32'(2'b11));
        step(3);
        check("overlap_held", 32'({sp_tdo[0], sp_tdo_oe[0]}), 32'(2'b11));
        tck_pulse(1'b1);
        tck_pulse(1'b1);
        tck_pulse(1'b0);
        check("overlap_od_hi", 32'({sp_tdo[0], sp_tdo_oe[0]}), 32'(2'b00));
        tdo_fpga[0] = 1'b0;
        #1 check("overlap_od_lo", 32'({sp_tdo[0], sp_tdo_oe[0]}), 32'(2'b01));

        // TRST tie-low forces TLR regardless of TMS.
        tck_pulse(1'b1);
        cfg_write(0, 1'b1, 8'hA0);
        step(1);
        check("trst_drive", 32'({sp_trst_n[0], sp_trst_n_oe[0]}), 32'(2'b01));
        step(SYNC);
        check("trst_early", 32'(tap_state[3:0]), 32'(4'h7));
        step(1);
        check("trst_reset", 32'(tap_state[3:0]), 32'(4'hF));
        trst_forced = 1'b1;
        exp_tap = 4'hF;
        tck_pulse(1'b0);

        // Release TRST, then 300 TCK edges.
        cfg_write(0, 1'b1, 8'h80);
        trst_forced = 1'b0;
        step(SYNC + 3);
        tms_fpga[0] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tck_fpga[0] = 1'b0;
            step(2);
            tck_fpga[0] = 1'b1;
            step(2);
        end
        step(SYNC + 2);
`ifdef SCANPORT_TCK_COUNT_EN
        check("tck_count_300", 32'(tck_count[15:0]), 32'(300));
`else
        check("tck_count_tied", 32'(tck_count[15:0]), 32'(0));
`endif
        check("tck_count_port1", 32'(tck_count[31:16]), 32'(0));
        check("tap_tlr_hold", 32'(tap_state[3:0]), 32'(4'hF));

        // Idle boundary.
        tck_fpga[0] = 1'b0;
        step(4);
        tck_fpga[0] = 1'b1;
        step(SYNC + IDLE);
        check("idle_boundary_minus1", 32'(port_idle[0]), 32'(0));
        step(1);
        check("idle_boundary", 32'(port_idle[0]), 32'(1));

        // Full mode table on port 1.
        for (int mi = 0; mi < 8; mi++) begin
            m = 3'(mi);
            for (int s = 0; s < 2; s++) begin
                cfg_write(1, 1'(s), {2'b10, m, m});
                step(1);
                for (int iv = 0; iv < 2; iv++) begin
                    in_v = 1'(iv);
                    tck_fpga[1] = in_v; tms_fpga[1] = in_v;
                    tdo_fpga[1] = in_v; trst_fpga[1] = in_v;
                    #1;
                    if (s == 0) begin
                        check($sformatf("mode%0d_tck_in%0d", mi, iv),
                              32'({sp_tck[1], sp_tck_oe[1]}), 32'(exp_pad(m, in_v)));
                        check($sformatf("mode%0d_tms_in%0d", mi, iv),
                              32'({sp_tms[1], sp_tms_oe[1]}), 32'(exp_pad(m, in_v)));
                    end else begin
                        check($sformatf("mode%0d_tdo_in%0d", mi, iv),
                              32'({sp_tdo[1], sp_tdo_oe[1]}), 32'(exp_pad(m, in_v)));
                        check($sformatf("mode%0d_trst_in%0d", mi, iv),
                              32'({sp_trst_n[1], sp_trst_n_oe[1]}), 32'(exp_pad(m, in_v)));
                    end
                end
                step(1);
            end
        end

        // Asynchronous reset mid-cycle.
        tck_fpga[0] = 1'b1;
        #1 check("pre_reset_drive", 32'(sp_tck_oe[0]), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("async_rst_oe", 32'({sp_tck_oe, sp_tms_oe, sp_tdo_oe, sp_trst_n_oe}), 32'(0));
        check("async_rst_val", 32'({sp_tck, sp_tms, sp_tdo, sp_trst_n}), 32'(0));
        check("async_rst_tap", 32'(tap_state), 32'(8'hFF));
        check("async_rst_idle", 32'(port_idle), 32'(2'b11));
        check("async_rst_count", tck_count, 32'(0));
        step(2);
        reset = 1'b0;
        step(2);

        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scanport_driver_bank.md
# scanport_driver_bank

Parametrised bank of NUM_PORTS JTAG scanport drivers with per-pin drive modes, glitch-safe deferred mode changes and clocked per-port TAP monitors. It sits between the I2C configuration slaves and the scanport pads. It replaces the per-port combinational driver muxes and the TCK-clocked monitors, so the whole bank runs in the system clock domain. Pad tristating happens at top level from the *_oe outputs.

## Interface
- NUM_PORTS, 2: number of scanports.
- SYNC_STAGES, 2: synchroniser depth for monitored TCK/TMS/TRST_N.
- IDLE_TIMEOUT, 1024: clk cycles without a TCK rising edge before port_idle asserts.
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-high reset.
- cfg_wr  in  1: one-cycle configuration write strobe.
- cfg_port  in  clog2(NUM_PORTS): target port.
- cfg_sel  in  1: 0 = TCK/TMS register, 1 = TDO/TRST register.
- cfg_data  in  8: [2:0] mode of TCK/TDO; [5:3] mode of TMS/TRST; [7] apply immediately; [6] ignored.
- cfg_ack  out  1: one-cycle pulse acknowledging a write.
- tck_fpga, tms_fpga, tdo_fpga, trst_fpga  in  NUM_PORTS each: test-controller signals.
- sp_tck, sp_tms, sp_tdo, sp_trst_n  out  NUM_PORTS each: pad drive value.
- sp_tck_oe, sp_tms_oe, sp_tdo_oe, sp_trst_n_oe  out  NUM_PORTS each: pad output enable.
- tap_state  out  4*NUM_PORTS: monitored TAP state per port, IEEE 1149.1 encoding.
- port_idle  out  NUM_PORTS: no TCK activity for IDLE_TIMEOUT cycles.
- tck_count  out  16*NUM_PORTS: TCK rising-edge counters (see Configuration).

## Operation
- Per-pin modes:
  - 000/011/111: hi-z (oe=0, value 0).
  - 001: open-drain pass-through (value 0, oe = ~in).
  - 010: open-source pass-through (value 1, oe = in).
  - 100: tie low.
  - 101: tie high.
  - 110: push-pull pass-through (oe=1, value = in).
- Each port has two 6-bit shadow registers and two 6-bit active registers. A write loads the shadow selected by cfg_port/cfg_sel and sets that register's pending flag.
- Shadow-to-active transfer happens on the first clk where pending=1 and any of these holds:
  - bit 7 of the write was set (immediate);
  - port_idle=1;
  - tap_state is TEST_LOGIC_RESET (F) or RUN_TEST_IDLE (C).
- Pending clears on transfer. If a new write lands on the same register in the transfer cycle, the old shadow goes active, the new data is stored in the shadow, and pending stays set.
- A write with cfg_port ≥ NUM_PORTS is acked and ignored.
- Per-port TAP monitor:
  - Synchronises the post-mux sp_tck, sp_tms and effective TRST_N. An undriven pin reads as 1.
  - Detects TCK rising edges and advances the 16-state 1149.1 FSM using the synchronised TMS.
  - Synchronised TRST_N=0 forces TEST_LOGIC_RESET and overrides any edge.
- Idle counter: cleared on a TCK edge, otherwise increments and saturates at IDLE_TIMEOUT. port_idle = (count == IDLE_TIMEOUT).

## Timing
- Reset values:
  - all active and shadow modes 000, so every *_oe=0 and every value=0;
  - pending=0; cfg_ack=0;
  - tap_state=F per port;
  - idle counter saturated, so port_idle=1;
  - tck_count=0.
- Pad path is combinational from the active mode and the fpga inputs, with zero clk latency for pass-through.
- Write accepted at edge N. The earliest transfer is at edge N+1, and pads change after N+1. cfg_ack is high during cycle N+1.
- Monitor latency is SYNC_STAGES+1 clk cycles from TCK edge to tap_state update. clk frequency must be ≥ 4× TCK.
- Reset asserted mid-operation forces all reset values immediately (asynchronous), including pad hi-z.

## Configuration
- SCANPORT_TCK_COUNT_EN defined: per port, a 16-bit wrapping counter of synchronised TCK rising edges, cleared by reset and by any write to that port.
- SCANPORT_TCK_COUNT_EN undefined: tck_count is tied to 0 and no counter logic is generated.

## Structure
- Shared package/include scanport_pkg:
  - mode codes (MODE_HIZ, MODE_OD, MODE_OS, MODE_LOW, MODE_HIGH, MODE_PP);
  - 4-bit TAP state constants;
  - cfg_data field positions.
- Sub-module tap_monitor, instantiated once per port. It contains the synchronisers, edge detect, TAP FSM, idle counter and optional edge counter.
- Top level holds the config registers, pending logic and output muxes.

## Test plan
- Reset with all inputs toggling -> all *_oe=0, tap_state=F on both ports, port_idle=2'b11.
- Write port 0, sel 0, data 8'h36 (TCK=110, TMS=110) with port idle -> pending transfers at N+1, cfg_ack pulse at N+1, sp_tck follows tck_fpga with oe=1.
- Drive TMS sequence 0,1,0,0 over four TCK pulses from TLR -> tap_state F→C→7→6→2.
- In SHIFT_DR with TCK running, write TDO mode 100 without bit 7 -> no change while in SHIFT_DR. Move to RTI -> sp_tdo_oe=1, sp_tdo=0 within one clk.
- Same write with bit 7 set while in SHIFT_DR -> applied at N+1.
- TRST mode 100 -> tap_state=F within SYNC_STAGES+1 cycles regardless of TMS. With SCANPORT_TCK_COUNT_EN, 300 TCK edges -> tck_count=300.
